// File: rtl/fc_pkg.sv
// Shared types and sizing for the FC classification front end.
// Frame geometry, controller state encoding and the timeout class code.
package fc_pkg;

   localparam int N_SCORES = 10;
   localparam int DATA_W   = 16;
   localparam int IDX_W    = 4;

   localparam logic [IDX_W-1:0] CLASS_TIMEOUT = '1;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } fc_state_e;

   typedef logic [DATA_W-1:0] score_t;

endpackage

// File: rtl/fc_score_buffer.sv
// N-entry score register file, written one entry per cycle at wr_idx_i.
// Write lands on the clock edge; scores_o is the flattened register contents.
module fc_score_buffer
   import fc_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         wr_en_i,
   input  logic [IDX_W-1:0]             wr_idx_i,
   input  logic [DATA_W-1:0]            wr_data_i,
   output logic [N_SCORES*DATA_W-1:0]   scores_o
);

   score_t mem_q [N_SCORES];

   // Compare-per-entry decode keeps out-of-range indices harmless.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_SCORES; k++) begin
            mem_q[k] <= '0;
         end
      end else if (wr_en_i) begin
         for (int k = 0; k < N_SCORES; k++) begin
            if (wr_idx_i == IDX_W'(k)) begin
               mem_q[k] <= wr_data_i;
            end
         end
      end
   end

   for (genvar g = 0; g < N_SCORES; g++) begin : g_flat
      assign scores_o[g*DATA_W +: DATA_W] = mem_q[g];
   end

endmodule

// File: rtl/fc_score_collector.sv
// Collects a 10-score frame, sequences the argmax comparator, returns the class.
// Clear at T+1 after last beat, result one cycle after done; out_ready low stalls in HOLD.
module fc_score_collector
   import fc_pkg::*;
#(
   parameter int TIMEOUT = 32
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [N_SCORES*DATA_W-1:0]   scores,
   output logic                         cmp_clear,
   output logic                         cmp_enable,
   input  logic                         cmp_done,
   input  logic [IDX_W-1:0]             cmp_result,
   output logic                         out_valid,
   output logic [IDX_W-1:0]             out_class,
   input  logic                         out_ready,
   output logic                         err_len,
   output logic                         err_timeout
);

   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   fc_state_e        state_q;
   logic [IDX_W-1:0] wr_idx_q;
   logic [WD_W-1:0]  wdog_q;
   logic             cmp_clear_q;
   logic             cmp_enable_q;
   logic             out_valid_q;
   logic [IDX_W-1:0] out_class_q;
   logic             err_len_q;
   logic             err_timeout_q;

   logic             beat_acc;
   logic             beat_full;

   assign in_ready  = (state_q == ST_FILL);
   assign beat_acc  = in_valid && in_ready;
   assign beat_full = (wr_idx_q == IDX_W'(N_SCORES - 1));

   fc_score_buffer u_buf (
      .clk_i     (clk),
      .rst_ni    (reset),
      .wr_en_i   (beat_acc),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (in_data),
      .scores_o  (scores)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_FILL;
         wr_idx_q      <= '0;
         wdog_q        <= '0;
         cmp_clear_q   <= 1'b0;
         cmp_enable_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         out_class_q   <= '0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (beat_acc) begin
                  if (beat_full) begin
                     // A full frame is processed even if in_last was missing.
                     wr_idx_q    <= '0;
                     cmp_clear_q <= 1'b1;
                     state_q     <= ST_CLEAR;
                     if (!in_last) begin
                        err_len_q <= 1'b1;
                     end
                  end else if (in_last) begin
                     wr_idx_q  <= '0;
                     err_len_q <= 1'b1;
                  end else begin
                     wr_idx_q <= wr_idx_q + 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               cmp_clear_q  <= 1'b0;
               cmp_enable_q <= 1'b1;
               wdog_q       <= '0;
               state_q      <= ST_RUN;
            end
            ST_RUN: begin
               if (cmp_done) begin
                  out_class_q  <= cmp_result;
                  cmp_enable_q <= 1'b0;
                  out_valid_q  <= 1'b1;
                  wdog_q       <= '0;
                  state_q      <= ST_HOLD;
               end else if (wdog_q == WD_LAST) begin
                  out_class_q   <= CLASS_TIMEOUT;
                  err_timeout_q <= 1'b1;
                  cmp_enable_q  <= 1'b0;
                  out_valid_q   <= 1'b1;
                  wdog_q        <= '0;
                  state_q       <= ST_HOLD;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_FILL;
               end
            end
            default: begin
               state_q <= ST_FILL;
            end
         endcase
      end
   end

   assign cmp_clear   = cmp_clear_q;
   assign cmp_enable  = cmp_enable_q;
   assign out_valid   = out_valid_q;
   assign out_class   = out_class_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;

   a_clr_en_excl : assert property (@(posedge clk) disable iff (!reset)
      !(cmp_clear && cmp_enable));

   a_hold_stable : assert property (@(posedge clk) disable iff (!reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_class)));

   a_scores_frozen : assert property (@(posedge clk) disable iff (!reset)
      (state_q != ST_FILL) |=> $stable(scores));

endmodule

// File: tb/tb_fc_score_collector.sv
// Scoreboarded bench for fc_score_collector with a behavioural argmax comparator.
module tb_fc_score_collector;
   import fc_pkg::*;

   logic                       clk = 1'b0;
   logic                       reset = 1'b0;
   logic                       in_valid = 1'b0;
   logic [DATA_W-1:0]          in_data = '0;
   logic                       in_last = 1'b0;
   logic                       in_ready;
   logic [N_SCORES*DATA_W-1:0] scores;
   logic                       cmp_clear;
   logic                       cmp_enable;
   logic                       cmp_done;
   logic [IDX_W-1:0]           cmp_result;
   logic                       out_valid;
   logic [IDX_W-1:0]           out_class;
   logic                       out_ready = 1'b1;
   logic                       err_len;
   logic                       err_timeout;

   always #5 clk = ~clk;

   fc_score_collector dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .scores      (scores),
      .cmp_clear   (cmp_clear),
      .cmp_enable  (cmp_enable),
      .cmp_done    (cmp_done),
      .cmp_result  (cmp_result),
      .out_valid   (out_valid),
      .out_class   (out_class),
      .out_ready   (out_ready),
      .err_len     (err_len),
      .err_timeout (err_timeout)
   );

   typedef struct packed {
      logic [IDX_W-1:0] cls;
      logic             el;
      logic             et;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   clr_cnt = 0;
   int   en_cnt = 0;
   int   overlap = 0;
   bit   hang = 1'b0;
   int   cmp_lat = 3;
   int   m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [IDX_W-1:0] argmax(input logic [N_SCORES*DATA_W-1:0] s);
      logic [DATA_W-1:0] best;
      logic [IDX_W-1:0]  bi;
      best = s[DATA_W-1:0];
      bi   = '0;
      for (int k = 1; k < N_SCORES; k++) begin
         if (s[k*DATA_W +: DATA_W] > best) begin
            best = s[k*DATA_W +: DATA_W];
            bi   = IDX_W'(k);
         end
      end
      return bi;
   endfunction

   // Comparator model: done a fixed number of enabled cycles after clear, or never when hung.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmp_done   <= 1'b0;
         cmp_result <= '0;
         m_cnt      <= 0;
      end else if (cmp_clear) begin
         cmp_done <= 1'b0;
         m_cnt    <= 0;
      end else if (cmp_enable && !cmp_done && !hang) begin
         if (m_cnt == cmp_lat - 1) begin
            cmp_done   <= 1'b1;
            cmp_result <= argmax(scores);
         end
         m_cnt <= m_cnt + 1;
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      if (reset) begin
         if (cmp_clear) begin
            clr_cnt++;
            en_cnt = 0;
         end
         if (cmp_enable) en_cnt++;
         if (cmp_clear && cmp_enable) overlap++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'(out_class), 32'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_class", 32'(out_class), 32'(e.cls));
               chk("err_len_at_out", 32'(err_len), 32'(e.el));
               chk("err_timeout_at_out", 32'(err_timeout), 32'(e.et));
            end
         end
      end
   end

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] v [N_SCORES], input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         send_beat(v[i], (i == last_at));
      end
   endtask

   task automatic wait_valid(input string name);
      int t;
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) chk(name, 32'(out_valid), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [DATA_W-1:0] fa [N_SCORES];
   logic [DATA_W-1:0] fb [N_SCORES];
   logic [DATA_W-1:0] fc [N_SCORES];
   logic [DATA_W-1:0] fd [N_SCORES];
   int c0, bad;

   initial begin
      fa = '{16'd5, 16'd9, 16'd3, 16'd100, 16'd7, 16'd2, 16'd8, 16'd1, 16'd0, 16'd4};
      fb = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'hFFFF};
      fc = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd500, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
      fd = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd77, 16'd0, 16'd0, 16'd0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_cmp_clear", 32'(cmp_clear), 32'd0);
      chk("rst_cmp_enable", 32'(cmp_enable), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_class", 32'(out_class), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      chk("rst_scores_zero", 32'(scores != '0), 32'd0);

      // Normal frame with latency checks.
      c0 = clr_cnt;
      exp_q.push_back('{cls: 4'd3, el: 1'b0, et: 1'b0});
      send_frame(fa, 10, 9);
      @(negedge clk);
      chk("t1_clear_high", 32'(cmp_clear), 32'd1);
      chk("t1_enable_low", 32'(cmp_enable), 32'd0);
      chk("t1_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("t1_clear_low", 32'(cmp_clear), 32'd0);
      chk("t1_enable_high", 32'(cmp_enable), 32'd1);
      wait_valid("t1_valid_timeout");
      @(negedge clk);
      chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);
      chk("t1_in_ready_after", 32'(in_ready), 32'd1);
      chk("t1_clear_pulses", 32'(clr_cnt - c0), 32'd1);
      chk("t1_scores_entry3", 32'(scores[3*DATA_W +: DATA_W]), 32'd100);

      // Short frame is discarded, then a full frame with max at the last entry.
      c0 = clr_cnt;
      send_frame(fb, 4, 3);
      @(negedge clk);
      chk("t2_err_len", 32'(err_len), 32'd1);
      chk("t2_stay_fill", 32'(in_ready), 32'd1);
      chk("t2_no_clear", 32'(clr_cnt - c0), 32'd0);
      exp_q.push_back('{cls: 4'd9, el: 1'b1, et: 1'b0});
      send_frame(fb, 10, 9);
      wait_valid("t2_valid_timeout");
      @(negedge clk);

      // Full frame with no in_last.
      do_reset();
      exp_q.push_back('{cls: 4'd4, el: 1'b1, et: 1'b0});
      send_frame(fc, 10, -1);
      @(negedge clk);
      chk("t3_err_len", 32'(err_len), 32'd1);
      chk("t3_clear_high", 32'(cmp_clear), 32'd1);
      wait_valid("t3_valid_timeout");
      @(negedge clk);

      // Comparator never finishes: watchdog expiry.
      do_reset();
      hang = 1'b1;
      exp_q.push_back('{cls: 4'hF, el: 1'b0, et: 1'b1});
      send_frame(fa, 10, 9);
      wait_valid("t4_valid_timeout");
      chk("t4_run_cycles", 32'(en_cnt), 32'd32);
      chk("t4_enable_low", 32'(cmp_enable), 32'd0);
      @(negedge clk);
      hang = 1'b0;

      // Backpressure on the output.
      out_ready = 1'b0;
      exp_q.push_back('{cls: 4'd6, el: 1'b0, et: 1'b1});
      send_frame(fd, 10, 9);
      wait_valid("t5_valid_timeout");
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || out_class !== 4'd6 || in_ready !== 1'b0) bad++;
      end
      chk("t5_hold_stable", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_in_ready_after", 32'(in_ready), 32'd1);
      chk("t5_valid_dropped", 32'(out_valid), 32'd0);

      // Reset asserted mid-RUN.
      hang = 1'b1;
      send_frame(fa, 10, 9);
      c0 = 0;
      while (!cmp_enable && c0 < 50) begin
         @(negedge clk);
         c0++;
      end
      chk("t6_reached_run", 32'(cmp_enable), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("t6_rst_enable", 32'(cmp_enable), 32'd0);
      chk("t6_rst_clear", 32'(cmp_clear), 32'd0);
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_out_class", 32'(out_class), 32'd0);
      chk("t6_rst_err_timeout", 32'(err_timeout), 32'd0);
      chk("t6_rst_scores_zero", 32'(scores != '0), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      hang  = 1'b0;
      #1;
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back('{cls: 4'd3, el: 1'b0, et: 1'b0});
      send_frame(fa, 10, 9);
      wait_valid("t6_valid_timeout");
      @(negedge clk);

      c0 = 0;
      while (exp_q.size() != 0 && c0 < 50) begin
         @(negedge clk);
         c0++;
      end
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("clear_enable_overlap", 32'(overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_score_collector.md
# fc_score_collector

Front end of the FC classification stage. It collects the 16-bit FC neuron scores streamed in one per beat into a 10-entry score buffer and presents that buffer to the `Comparitor` argmax block. It sequences that block's synchronous `reset` and `enable` and waits for its `done`. It then returns the winning class index on a valid/ready output, with length and timeout error reporting.

## Interface
- `N_SCORES`, 10: entries per frame (number of classes).
- `DATA_W`, 16: score width.
- `IDX_W`, 4: class index width.
- `TIMEOUT`, 32: maximum cycles in RUN before the watchdog fires.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: score beat valid.
- `in_data`  in  DATA_W: score value, unsigned.
- `in_last`  in  1: marks the final beat of a frame.
- `in_ready`  out  1: collector accepts a beat.
- `scores`  out  N_SCORES*DATA_W: buffer contents; entry k occupies bits [k*DATA_W +: DATA_W]; drives comparator `Arr`.
- `cmp_clear`  out  1: one-cycle pulse to the comparator's `reset`.
- `cmp_enable`  out  1: drives the comparator's `enable`.
- `cmp_done`  in  1: comparator `done`.
- `cmp_result`  in  IDX_W: comparator `result`.
- `out_valid`  out  1: class result valid.
- `out_class`  out  IDX_W: winning index; all-ones on timeout.
- `out_ready`  in  1: downstream accepts the result.
- `err_len`  out  1: sticky in_last/frame-length mismatch.
- `err_timeout`  out  1: sticky watchdog expiry.

## Operation
- The state machine has four states: FILL, CLEAR, RUN, HOLD. Reset state is FILL.
- FILL
  - `in_ready` = 1 in FILL only (decoded from state).
  - An accepted beat (`in_valid && in_ready`) writes `in_data` into entry `wr_idx`, then `wr_idx` increments.
  - Accepted beat with `wr_idx == N_SCORES-1`: `wr_idx` → 0, go to CLEAR. If `in_last == 0` on this beat, set `err_len`; the frame is still processed.
  - Accepted beat with `in_last == 1` and `wr_idx < N_SCORES-1`: set `err_len`, `wr_idx` → 0, stay in FILL. The partial frame is discarded; stale buffer entries are overwritten by the next frame.
- CLEAR: `cmp_clear` = 1 for exactly this one cycle; go to RUN.
- RUN
  - `cmp_enable` = 1 and the watchdog counts up from 0.
  - `cmp_done` sampled 1: capture `cmp_result` into `out_class`; go to HOLD.
  - Watchdog reaches `TIMEOUT-1` with `cmp_done` = 0: `out_class` ← all-ones, set `err_timeout`, go to HOLD.
  - If `cmp_done` and expiry coincide, `cmp_done` wins.
- HOLD: `out_valid` = 1 and `out_class` is held stable. On `out_valid && out_ready`, go to FILL.
- The buffer is written only in FILL, so `scores` is frozen during CLEAR, RUN and HOLD.
- `cmp_clear` and `cmp_enable` are never high in the same cycle.
- The error flags clear only on reset.

## Timing
- Reset values: `cmp_clear`, `cmp_enable`, `out_valid`, `err_len`, `err_timeout` = 0; `out_class` = 0; all buffer entries = 0; `wr_idx` and the watchdog = 0.
- `in_ready` reads 1 as soon as reset deasserts.
- All outputs except `in_ready` are registered.
- Latency:
  - The last beat is accepted at edge T.
  - `cmp_clear` is high in cycle T+1.
  - `cmp_enable` is high from cycle T+2.
  - `cmp_done` is sampled at edge D.
  - `out_valid` is high from D+1.
- After the out handshake at edge H, `in_ready` = 1 in cycle H+1.
- Backpressure: `out_ready` held 0 keeps HOLD indefinitely, with `in_ready` = 0.
- Reset asserted mid-frame or mid-RUN returns all state to reset values immediately; any in-progress frame is lost.

## Structure
- A shared `fc_pkg` holds:
  - the state enum;
  - `N_SCORES`, `DATA_W`, `IDX_W`;
  - `CLASS_TIMEOUT` = all-ones.
- One natural sub-module: `fc_score_buffer`, the N-entry write-indexed register file with the flattened `scores` output.
- FSM and watchdog stay in the top.

## Test plan
- Scores 5,9,3,100,7,2,8,1,0,4 with `in_last` on beat 10, `out_ready` = 1 → `cmp_clear` pulses once, then `out_class` = 3 with `out_valid` for 1 cycle; no errors.
- `in_last` on beat 4 → `err_len` = 1, stays in FILL. Next full frame with max 0xFFFF at entry 9 → `out_class` = 9.
- 10 beats with no `in_last` → `err_len` = 1; result still produced.
- Comparator model never raises `cmp_done` → after 32 RUN cycles, `out_class` = 0xF and `err_timeout` = 1.
- `out_ready` held 0 for 20 cycles → `out_valid` and `out_class` stable, `in_ready` = 0; release → FILL next cycle.
- Reset pulsed during RUN → all outputs return to reset values; the next frame completes normally.
